// File: rtl/fp32_add_arbiter.sv
// Shares one fp32 adder between NUM_REQ requesters; a tag FIFO routes results back in issue order.
// Define FP_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority instead of round-robin.
module fp32_add_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int TAG_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [31:0]            rsp_result,
  output logic [31:0]            add_a,
  output logic [31:0]            add_b,
  output logic                   add_in_valid,
  input  logic                   add_in_ready,
  input  logic [31:0]            add_result,
  input  logic                   add_out_valid,
  output logic                   add_out_ready,
  output logic                   busy,
  output logic                   err
);

  localparam int TAG_W = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);

  logic [31:0]      op_a [NUM_REQ];
  logic [31:0]      op_b [NUM_REQ];
  logic [TAG_W-1:0] grant;
  logic [TAG_W-1:0] tag_mem_reg [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             err_reg;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [TAG_W-1:0] head_tag;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign op_a[gi] = req_a[32*gi +: 32];
    assign op_b[gi] = req_b[32*gi +: 32];
  end

`ifdef FP_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) grant = TAG_W'(i);
    end
  end
`else
  logic [TAG_W-1:0] rr_ptr_reg;
  logic [TAG_W-1:0] rr_ptr_next;
  logic             found;

  // Two passes: indices at/after the pointer first, then wrap to the low indices.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (TAG_W'(i) >= rr_ptr_reg)) begin
        found = 1'b1;
        grant = TAG_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        found = 1'b1;
        grant = TAG_W'(i);
      end
    end
    rr_ptr_next = (grant == TAG_W'(NUM_REQ - 1)) ? '0 : TAG_W'(grant + 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg <= '0;
    end else if (push) begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end
`endif

  assign fifo_full    = (count_reg == FULL_CNT);
  assign fifo_empty   = (count_reg == '0);
  assign head_tag     = tag_mem_reg[rd_ptr_reg];
  assign add_in_valid = (|req_valid) && !fifo_full;
  assign add_a        = op_a[grant];
  assign add_b        = op_b[grant];
  assign push         = add_in_valid && add_in_ready;
  // An unexpected result with nothing in flight is drained rather than left to wedge the adder.
  assign add_out_ready = fifo_empty ? 1'b1 : rsp_ready[head_tag];
  assign pop          = add_out_valid && !fifo_empty && rsp_ready[head_tag];
  assign rsp_result   = add_result;
  assign busy         = !fifo_empty;
  assign err          = err_reg;

  always_comb begin
    req_ready           = '0;
    req_ready[grant]    = push;
    rsp_valid           = '0;
    rsp_valid[head_tag] = add_out_valid && !fifo_empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      err_reg    <= 1'b0;
      for (int i = 0; i < TAG_DEPTH; i++) tag_mem_reg[i] <= '0;
    end else begin
      if (push) begin
        tag_mem_reg[wr_ptr_reg] <= grant;
        wr_ptr_reg              <= wr_ptr_reg + 1'b1;
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      if (add_out_valid && fifo_empty) err_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fp32_add_arbiter.sv
// Directed bench for fp32_add_arbiter with a 2-cycle adder stub and an issue-order scoreboard.
// Expected grant orders follow FP_ARB_FIXED_PRIO_EN when it is defined.
module tb_fp32_add_arbiter;

  localparam int N = 4;
  localparam int D = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [31:0]     rsp_result;
  logic [31:0]     add_a;
  logic [31:0]     add_b;
  logic            add_in_valid;
  logic            add_in_ready;
  logic [31:0]     add_result;
  logic            add_out_valid;
  logic            add_out_ready;
  logic            busy;
  logic            err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ia [N];
  int ib [N];
  logic stub_in_ready;
  logic force_out;

  typedef struct { int tag; logic [31:0] res; } sb_t;
  sb_t  sb [$];
  int   issue_log [$];
  int   rsp_log [$];
  int   rr_model;
  int   last_iss_cyc;
  int   last_rsp_cyc;
  logic [31:0] last_rsp_result;

  fp32_add_arbiter #(.NUM_REQ(N), .TAG_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .add_a(add_a), .add_b(add_b), .add_in_valid(add_in_valid), .add_in_ready(add_in_ready),
    .add_result(add_result), .add_out_valid(add_out_valid), .add_out_ready(add_out_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] int_to_fp(input int n);
    int p;
    logic [31:0] m;
    if (n <= 0) return 32'h0;
    p = 0;
    for (int k = 0; k < 24; k++) if (n >= (1 << k)) p = k;
    m = 32'(n) << (23 - p);
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  function automatic int fp_to_int(input logic [31:0] f);
    int e;
    logic [31:0] m;
    if (f[30:0] == 31'h0) return 0;
    e = int'(f[30:23]) - 127;
    m = {8'h0, 1'b1, f[22:0]};
    return int'(m >> (23 - e));
  endfunction

  function automatic int model_grant(input logic [N-1:0] v, input int ptr);
    int i;
`ifdef FP_ARB_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) if (v[k]) return k;
`else
    for (int off = 0; off < N; off++) begin
      i = (ptr + off) % N;
      if (v[i]) return i;
    end
`endif
    return 0;
  endfunction

  for (genvar gi = 0; gi < N; gi++) begin : g_ops
    assign req_a[32*gi +: 32] = int_to_fp(ia[gi]);
    assign req_b[32*gi +: 32] = int_to_fp(ib[gi]);
  end

  // Adder stub: unbounded-ish result ring, each result visible two edges after acceptance.
  logic [31:0] st_res [16];
  int          st_rdy [16];
  logic [3:0]  st_wp;
  logic [3:0]  st_rp;
  logic        st_has;
  assign st_has        = (st_wp != st_rp) && (cyc >= st_rdy[st_rp]);
  assign add_in_ready  = stub_in_ready;
  assign add_out_valid = st_has || force_out;
  assign add_result    = st_res[st_rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_wp <= '0;
      st_rp <= '0;
    end else begin
      if (add_in_valid && add_in_ready) begin
        st_res[st_wp] <= int_to_fp(fp_to_int(add_a) + fp_to_int(add_b));
        st_rdy[st_wp] <= cyc + 2;
        st_wp         <= st_wp + 1'b1;
      end
      if (st_has && add_out_ready) st_rp <= st_rp + 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge against the model, then advance past the rising edge.
  task automatic tick();
    int g;
    logic exp_iv;
    logic [N-1:0] exp_rr;
    logic [N-1:0] exp_rv;
    int obs_idx;
    @(negedge clk);
    if (!rst_n) begin
      sb.delete();
      rr_model = 0;
    end else begin
      exp_iv = (|req_valid) && (sb.size() < D);
      g      = model_grant(req_valid, rr_model);
      exp_rr = (exp_iv && add_in_ready) ? N'(1 << g) : '0;
      chk("add_in_valid", 32'(add_in_valid), 32'(exp_iv));
      chk("req_ready", 32'(req_ready), 32'(exp_rr));
      if (exp_iv) begin
        chk("add_a", add_a, int_to_fp(ia[g]));
        chk("add_b", add_b, int_to_fp(ib[g]));
      end
      exp_rv = (add_out_valid && sb.size() > 0) ? N'(1 << sb[0].tag) : '0;
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      chk("busy", 32'(busy), 32'(sb.size() != 0));
      if (add_out_valid)
        chk("add_out_ready", 32'(add_out_ready),
            (sb.size() == 0) ? 32'd1 : 32'(rsp_ready[sb[0].tag]));
      if (exp_rv != '0) chk("rsp_result", rsp_result, sb[0].res);
      if (add_out_valid && sb.size() > 0 && rsp_ready[sb[0].tag]) begin
        obs_idx = -1;
        for (int k = 0; k < N; k++) if (rsp_valid[k]) obs_idx = k;
        rsp_log.push_back(obs_idx);
        last_rsp_cyc    = cyc;
        last_rsp_result = rsp_result;
        void'(sb.pop_front());
      end
      if (exp_iv && add_in_ready) begin
        sb.push_back('{tag: g, res: int_to_fp(ia[g] + ib[g])});
        issue_log.push_back(g);
        last_iss_cyc = cyc;
        rr_model = (g + 1) % N;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int exp_order [6];
    int n_before;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order [6];
    int n_before;
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    stub_in_ready = 1'b1;
    force_out = 1'b0;
    for (int k = 0; k < N; k++) begin
      ia[k] = 0;
      ib[k] = 0;
    end
    ticks(3);
    rst_n = 1'b1;
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_add_in_valid", 32'(add_in_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Single transaction 1.0 + 2.0 from requester 1.
    ia[1] = 1;
    ib[1] = 2;
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    drain();
    chk("lat", 32'(last_rsp_cyc - last_iss_cyc), 32'd2);
    chk("sum_3", last_rsp_result, 32'h40400000);

    // All requesters valid: grant order and matching response order.
    reset_pulse();
    issue_log.delete();
    rsp_log.delete();
    for (int k = 0; k < N; k++) begin
      ia[k] = 10 + k;
      ib[k] = k;
    end
`ifdef FP_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0, 1};
`endif
    req_valid = 4'b1111;
    ticks(6);
    req_valid = '0;
    drain();
    chk("n_issue", 32'(issue_log.size()), 32'd6);
    chk("n_rsp", 32'(rsp_log.size()), 32'd6);
    for (int k = 0; k < 6 && k < issue_log.size() && k < rsp_log.size(); k++) begin
      chk("grant_order", 32'(issue_log[k]), 32'(exp_order[k]));
      chk("rsp_order", 32'(rsp_log[k]), 32'(exp_order[k]));
    end

    // Adder not ready: valid stays up, nothing accepted.
    req_valid = 4'b0100;
    stub_in_ready = 1'b0;
    ticks(2);
    chk("no_ready_valid", 32'(add_in_valid), 32'd1);
    chk("no_ready_rr", 32'(req_ready), 32'd0);

    // Requester 2 blocked at the head: FIFO fills and issue stops.
    stub_in_ready = 1'b1;
    rsp_ready = 4'b1011;
    tick();
    req_valid = 4'b1111;
    ticks(8);
    chk("full_req_ready", 32'(req_ready), 32'd0);
    chk("full_add_out_ready", 32'(add_out_ready), 32'd0);
    chk("full_in_valid", 32'(add_in_valid), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    rsp_ready = 4'b1111;
    n_before = issue_log.size();
    ticks(6);
    chk("resume", 32'(issue_log.size() > n_before), 32'd1);
    req_valid = '0;
    drain();

    // Steady push+pop at occupancy 2 across several pointer wraps.
    for (int k = 0; k < N; k++) begin
      ia[k] = 3 * k + 1;
      ib[k] = 5;
    end
    req_valid = 4'b1111;
    ticks(3);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("busy_steady", 32'(busy), 32'd1);
    end

    // Reset mid-flight discards everything.
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_in_valid", 32'(add_in_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    ticks(4);
    chk("post_rst_rsp", 32'(rsp_valid), 32'd0);

    // Unexpected adder output with empty FIFO.
    force_out = 1'b1;
    tick();
    force_out = 1'b0;
    chk("err_set", 32'(err), 32'd1);
    ticks(5);
    chk("err_sticky", 32'(err), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("err_clear", 32'(err), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Requesters 0 and 3 continuously valid.
    issue_log.delete();
`ifdef FP_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0, 0};
`else
    exp_order = '{0, 3, 0, 3, 0, 3};
`endif
    req_valid = 4'b1001;
    ticks(6);
    req_valid = '0;
    drain();
    chk("n_issue_03", 32'(issue_log.size()), 32'd6);
    for (int k = 0; k < 6 && k < issue_log.size(); k++)
      chk("grant_03", 32'(issue_log[k]), 32'(exp_order[k]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp32_add_arbiter.md
FP32_ADD_ARBITER -- requirements
Module: fp32_add_arbiter

Interface
- REQ-001: Parameter NUM_REQ, default 4; number of requesters sharing one fp32_adder (range 2..8).
- REQ-002: Parameter TAG_DEPTH, default 4; in-flight tag FIFO depth (power of 2, at least 2).
- REQ-003: clk  input  1  single clock; all logic on its rising edge.
- REQ-004: rst_n  input  1  asynchronous active-low reset.
- REQ-005: req_valid  input  NUM_REQ  per-requester operand valid.
- REQ-006: req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- REQ-007: req_a  input  32*NUM_REQ  operand A; requester i occupies bits [32i+31:32i].
- REQ-008: req_b  input  32*NUM_REQ  operand B; same packing as req_a.
- REQ-009: rsp_valid  output  NUM_REQ  per-requester result valid; one-hot or zero.
- REQ-010: rsp_ready  input  NUM_REQ  per-requester result accept.
- REQ-011: rsp_result  output  32  shared result bus, valid for whichever rsp_valid bit is set.
- REQ-012: add_a, add_b  output  32 each  operands to adder.
- REQ-013: add_in_valid  output  1 / add_in_ready  input  1  adder input handshake.
- REQ-014: add_result  input  32 / add_out_valid  input  1 / add_out_ready  output  1  adder output handshake.
- REQ-015: busy  output  1  high while the tag FIFO is non-empty.
- REQ-016: err  output  1  sticky protocol-error flag.

Function
- REQ-017: Issue condition: any req_valid set and tag FIFO not full; add_in_valid equals this condition and does not depend on add_in_ready.
- REQ-018: Grant g is selected combinationally by round-robin, starting search at pointer rr_ptr; add_a/add_b are muxed from requester g.
- REQ-019: req_ready[g] = add_in_valid AND add_in_ready; all other req_ready bits are 0.
- REQ-020: On input handshake, tag g ($clog2(NUM_REQ) bits) is pushed into the tag FIFO and rr_ptr becomes (g+1) mod NUM_REQ; without a handshake rr_ptr holds.
- REQ-021: A full FIFO blocks issue even when a pop occurs in the same cycle.
- REQ-022: Results return in issue order; head tag h routes: rsp_valid[h] = add_out_valid AND FIFO non-empty; add_out_ready = rsp_ready[h]; rsp_result = add_result, combinational.
- REQ-023: On output handshake the head tag is popped.
- REQ-024: Simultaneous push and pop leave occupancy unchanged; occupancy stays within 0..TAG_DEPTH; read and write pointers wrap modulo TAG_DEPTH.
- REQ-025: If add_out_valid is high while the FIFO is empty, err is set and add_out_ready is driven 1 to drain; rsp_valid stays 0 and nothing is popped.
- REQ-026: err clears only on reset.
- REQ-027: Zero added latency: issue-to-response latency equals the adder latency, 2 cycles with no backpressure.
- REQ-028: Requester operands need not be held after req_ready; the adder registers them.

Reset
- REQ-029: Asserting rst_n low asynchronously empties the tag FIFO and sets rr_ptr=0 and err=0; consequently busy=0, req_ready=0, rsp_valid=0, and add_in_valid=0 while no request is pending.
- REQ-030: Reset asserted mid-operation discards all in-flight tags; the adder shares rst_n, so no stale results return.

Configuration
- REQ-031: Macro FP_ARB_FIXED_PRIO_EN defined: grant is the lowest-index valid requester, and rr_ptr is removed or held at 0.
- REQ-032: FP_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-018 and REQ-020.

Verification
- REQ-033: Requester 1 sends a=0x3F800000, b=0x40000000, all rsp_ready=1 -> rsp_valid[1] with rsp_result=0x40400000 two cycles after the handshake; busy returns to 0.
- REQ-034: All 4 req_valid held high, rsp_ready all 1 -> grant order 0,1,2,3,0,1; responses arrive in the same order to matching rsp_valid bits.
- REQ-035: rsp_ready[2]=0 with requester 2 at the FIFO head -> add_out_ready=0; FIFO fills to 4; all req_ready=0 until rsp_ready[2]=1, then issue resumes.
- REQ-036: Occupancy 2 with a push and a pop in the same cycle -> occupancy stays 2, busy=1, and pointer wrap is correct over 10+ cycles.
- REQ-037: add_out_valid forced high with the FIFO empty -> err=1 next cycle, add_out_ready=1, all rsp_valid=0; err persists until rst_n pulses low.
- REQ-038: With FP_ARB_FIXED_PRIO_EN defined and requesters 0 and 3 continuously valid -> requester 0 granted every cycle and requester 3 starved.
